// File: rtl/led_status_pkg.sv
// Shared mode/link-state codes, ms-period constants and the per-channel LED pattern decode.
package led_status_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_SLOW  = 3'd2,
    MODE_FAST  = 3'd3,
    MODE_PWM   = 3'd4,
    MODE_LINK  = 3'd5,
    MODE_HEART = 3'd6,
    MODE_RSVD  = 3'd7
  } led_mode_e;

  typedef enum logic [1:0] {
    LS_DOWN  = 2'd0,
    LS_TRAIN = 2'd1,
    LS_UP    = 2'd2,
    LS_LOST  = 2'd3
  } link_state_e;

  localparam logic [9:0] MS_LAST         = 10'd999;
  localparam logic [9:0] SLOW_ON_MS      = 10'd500;
  localparam logic [9:0] FAST_PERIOD_MS  = 10'd250;
  localparam logic [9:0] FAST_ON_MS      = 10'd125;
  localparam logic [9:0] HEART_BEAT0_END = 10'd100;
  localparam logic [9:0] HEART_BEAT1_BEG = 10'd200;
  localparam logic [9:0] HEART_BEAT1_END = 10'd300;

  function automatic logic led_pattern(input led_mode_e mode, input logic [9:0] ms,
                                       input link_state_e ls, input logic pwm_on);
    logic slow, fast, heart, res;
    slow  = ms < SLOW_ON_MS;
    fast  = (ms % FAST_PERIOD_MS) < FAST_ON_MS;
    heart = (ms < HEART_BEAT0_END) || ((ms >= HEART_BEAT1_BEG) && (ms < HEART_BEAT1_END));
    res   = 1'b0;
    case (mode)
      MODE_ON:    res = 1'b1;
      MODE_SLOW:  res = slow;
      MODE_FAST:  res = fast;
      MODE_PWM:   res = pwm_on;
      MODE_LINK: begin
        case (ls)
          LS_UP:    res = 1'b1;
          LS_TRAIN: res = fast;
          LS_LOST:  res = slow;
          default:  res = 1'b0;
        endcase
      end
      MODE_HEART: res = heart;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pcie_link_mon.sv
// Link FSM (DOWN/TRAIN/UP/LOST) with saturating drop counter; inputs pre-synchronised, state
// registered one clk after input change; no backpressure.
module pcie_link_mon
  import led_status_pkg::*;
#(
  parameter int TICK_DIV   = 250000,
  parameter int HOLD_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_up_i,
  input  logic        perst_n_i,
  output link_state_e state_o,
  output logic [15:0] drop_cnt_o
);

  // LOST hold is timed from LOST entry so it lasts exactly HOLD_TICKS tick periods.
  localparam int              HOLD_CLKS = TICK_DIV * HOLD_TICKS;
  localparam int              HW        = $clog2(HOLD_CLKS);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CLKS - 1);

  link_state_e   state_q;
  logic [HW-1:0] hold_q;
  logic [15:0]   drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LS_DOWN;
      hold_q  <= '0;
      drop_q  <= '0;
    end else if (!perst_n_i) begin
      state_q <= LS_DOWN;
      hold_q  <= '0;
    end else begin
      case (state_q)
        LS_DOWN:  state_q <= LS_TRAIN;
        LS_TRAIN: if (link_up_i) state_q <= LS_UP;
        LS_UP: begin
          if (!link_up_i) begin
            state_q <= LS_LOST;
            hold_q  <= '0;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
          end
        end
        LS_LOST: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= LS_TRAIN;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= LS_DOWN;
      endcase
    end
  end

  assign state_o    = state_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: rtl/pcie_led_status.sv
// PCIe LED status: per-channel pattern LEDs plus link monitor; LED registered one clk after change,
// cfg_ready held high outside reset. PWM mode only with LED_STATUS_PWM_EN (else mode 4 = ON).
module pcie_led_status
  import led_status_pkg::*;
#(
  parameter int NUM_LED    = 8,
  parameter int TICK_DIV   = 250000,
  parameter int HOLD_TICKS = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pcie_link_up,
  input  logic               pcie_perst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [3:0]         cfg_ch,
  input  logic [2:0]         cfg_mode,
  input  logic [7:0]         cfg_duty,
  output logic               cfg_err,
  output logic [NUM_LED-1:0] LED,
  output logic [1:0]         link_state,
  output logic [15:0]        link_drop_cnt
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [4:0]    NUM_LED_W = 5'(NUM_LED);

  logic [1:0]         link_up_sync_q, perst_sync_q;
  logic [TW-1:0]      tick_cnt_q;
  logic [9:0]         ms_q;
  logic               tick;
  logic               cfg_ready_q, cfg_err_q;
  logic               cfg_hit, cfg_wr_ok;
  led_mode_e          mode_q [NUM_LED];
  logic [NUM_LED-1:0] led_q, led_d, pwm_on;
  link_state_e        ls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_up_sync_q <= '0;
      perst_sync_q   <= '0;
    end else begin
      link_up_sync_q <= {link_up_sync_q[0], pcie_link_up};
      perst_sync_q   <= {perst_sync_q[0], pcie_perst_n};
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      ms_q       <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
      ms_q       <= (ms_q == MS_LAST) ? 10'd0 : ms_q + 10'd1;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  pcie_link_mon #(
    .TICK_DIV  (TICK_DIV),
    .HOLD_TICKS(HOLD_TICKS)
  ) u_link_mon (
    .clk       (clk),
    .rst       (rst),
    .link_up_i (link_up_sync_q[1]),
    .perst_n_i (perst_sync_q[1]),
    .state_o   (ls),
    .drop_cnt_o(link_drop_cnt)
  );

  assign cfg_hit   = cfg_valid && cfg_ready_q;
  assign cfg_wr_ok = cfg_hit && ({1'b0, cfg_ch} < NUM_LED_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < NUM_LED; i++) mode_q[i] <= (i == 0) ? MODE_LINK : MODE_OFF;
    end else begin
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= cfg_hit && !cfg_wr_ok;
      for (int i = 0; i < NUM_LED; i++)
        if (cfg_wr_ok && (cfg_ch == 4'(i))) mode_q[i] <= led_mode_e'(cfg_mode);
    end
  end

`ifdef LED_STATUS_PWM_EN
  logic [7:0] pwm_cnt_q;
  logic [7:0] duty_q [NUM_LED];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      for (int i = 0; i < NUM_LED; i++) duty_q[i] <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      for (int i = 0; i < NUM_LED; i++)
        if (cfg_wr_ok && (cfg_ch == 4'(i))) duty_q[i] <= cfg_duty;
    end
  end

  // Strict compare: duty 0 never lights, duty 255 lights 255 of 256 counts.
  always_comb begin
    pwm_on = '0;
    for (int i = 0; i < NUM_LED; i++) pwm_on[i] = pwm_cnt_q < duty_q[i];
  end
`else
  logic unused_cfg_duty;
  assign unused_cfg_duty = ^cfg_duty;
  assign pwm_on          = '1;
`endif

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LED; i++) led_d[i] = led_pattern(mode_q[i], ms_q, ls, pwm_on[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= '0;
    else     led_q <= led_d;
  end

  assign LED        = led_q;
  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign link_state = ls;

endmodule

// File: tb/tb_pcie_led_status.sv
// Directed + randomized bench for pcie_led_status against a cycle-arithmetic reference model.
module tb_pcie_led_status;

  localparam int NUM_LED    = 8;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 3;
`ifdef LED_STATUS_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pcie_link_up = 1'b0;
  logic               pcie_perst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [3:0]         cfg_ch = '0;
  logic [2:0]         cfg_mode = '0;
  logic [7:0]         cfg_duty = '0;
  logic               cfg_ready, cfg_err;
  logic [NUM_LED-1:0] LED;
  logic [1:0]         link_state;
  logic [15:0]        link_drop_cnt;

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc;
  int          m_mode [NUM_LED];
  int          m_duty [NUM_LED];
  int          m_ls;

  pcie_led_status #(
    .NUM_LED   (NUM_LED),
    .TICK_DIV  (TICK_DIV),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pcie_link_up (pcie_link_up),
    .pcie_perst_n (pcie_perst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_mode     (cfg_mode),
    .cfg_duty     (cfg_duty),
    .cfg_err      (cfg_err),
    .LED          (LED),
    .link_state   (link_state),
    .link_drop_cnt(link_drop_cnt)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; LED after edge e reflects time base after edge e-1.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  function automatic logic exp_led(input int mode, input int duty, input int unsigned e, input int ls);
    int   ms, pw;
    logic slow, fast, heart;
    ms    = int'(((e - 1) / TICK_DIV) % 1000);
    pw    = int'((e - 1) % 256);
    slow  = ms < 500;
    fast  = (ms % 250) < 125;
    heart = (ms < 100) || (ms >= 200 && ms < 300);
    case (mode)
      1: return 1'b1;
      2: return slow;
      3: return fast;
      4: return PWM ? (pw < duty) : 1'b1;
      5: return (ls == 2) || (ls == 1 && fast) || (ls == 3 && slow);
      6: return heart;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_LED-1:0] exp_vec();
    logic [NUM_LED-1:0] v;
    for (int i = 0; i < NUM_LED; i++) v[i] = exp_led(m_mode[i], m_duty[i], cyc, m_ls);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LED; i++) begin
      m_mode[i] = (i == 0) ? 5 : 0;
      m_duty[i] = 0;
    end
    m_ls = 0;
  endtask

  task automatic wait_state(input logic [1:0] tgt, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (link_state !== tgt && n < 10);
    chk(tag, 32'(link_state), 32'(tgt));
    chk({tag, "_latency"}, (n <= 3) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic lost_len(input string tag);
    int len = 1;
    while (len < 60) begin
      @(negedge clk);
      if (link_state !== 2'd3) break;
      len++;
    end
    chk(tag, 32'(len), 32'(TICK_DIV * HOLD_TICKS));
    chk({tag, "_then_train"}, 32'(link_state), 32'd1);
  endtask

  task automatic cfg_write(input int ch, input int mode, input int duty);
    cfg_ch    = 4'(ch);
    cfg_mode  = 3'(mode);
    cfg_duty  = 8'(duty);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), (ch >= NUM_LED) ? 32'd1 : 32'd0);
    if (ch < NUM_LED) begin
      m_mode[ch] = mode;
      m_duty[ch] = duty;
    end
    @(negedge clk);
    chk("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    chk("led_after_write", 32'(LED), 32'(exp_vec()));
  endtask

  task automatic run_check(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk(tag, 32'(LED), 32'(exp_vec()));
    end
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      chk("led_model", 32'(LED), 32'(exp_vec()));
      if (LED[ch]) hi++;
    end
  endtask

  initial begin
    int hi;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_link_state", 32'(link_state), 32'd0);
    chk("rst_drop_cnt", 32'(link_drop_cnt), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("cfg_ready_up", 32'(cfg_ready), 32'd1);
    chk("led_default", 32'(LED), 32'(exp_vec()));

    pcie_perst_n = 1'b1;
    wait_state(2'd1, "down_to_train");
    m_ls = 1;
    @(negedge clk);
    chk("led0_train_fast", 32'(LED[0]), 32'(exp_led(5, 0, cyc, 1)));
    pcie_link_up = 1'b1;
    wait_state(2'd2, "train_to_up");
    m_ls = 2;
    @(negedge clk);
    chk("led0_up", 32'(LED[0]), 32'd1);

    pcie_link_up = 1'b0;
    wait_state(2'd3, "up_to_lost");
    lost_len("lost_hold");
    chk("drop_cnt_1", 32'(link_drop_cnt), 32'd1);

    pcie_link_up = 1'b1;
    wait_state(2'd2, "retrain_up");
    m_ls = 2;

    cfg_write(2, 2, 0);
    count_high(2, 8000, hi);
    chk("slow_high_cycles", 32'(hi), 32'd4000);

    cfg_write(9, 3, 0);
    run_check(4, "ch9_no_change");

    cfg_write(1, 4, 64);
    count_high(1, 512, hi);
    chk("pwm_duty64", 32'(hi), PWM ? 32'd128 : 32'd512);
    cfg_write(3, 4, 0);
    count_high(3, 256, hi);
    chk("pwm_duty0", 32'(hi), PWM ? 32'd0 : 32'd256);
    cfg_write(3, 4, 255);
    count_high(3, 256, hi);
    chk("pwm_duty255", 32'(hi), PWM ? 32'd255 : 32'd256);

    repeat (40) begin
      cfg_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      run_check(int'($urandom_range(1, 30)), "rand_led");
    end

    pcie_link_up = 1'b0;
    wait_state(2'd3, "up_to_lost2");
    repeat (4) @(negedge clk);
    pcie_perst_n = 1'b0;
    wait_state(2'd0, "perst_lost_to_down");
    chk("drop_cnt_kept", 32'(link_drop_cnt), 32'd2);
    repeat (20) @(negedge clk);
    chk("down_holds", 32'(link_state), 32'd0);

    pcie_perst_n = 1'b1;
    wait_state(2'd1, "down_to_train3");
    pcie_link_up = 1'b1;
    wait_state(2'd2, "train_to_up3");
    pcie_link_up = 1'b0;
    wait_state(2'd3, "up_to_lost3");
    lost_len("lost_hold_fresh");
    chk("drop_cnt_3", 32'(link_drop_cnt), 32'd3);

    pcie_perst_n = 1'b0;
    repeat (5) @(negedge clk);
    cfg_ch    = 4'd4;
    cfg_mode  = 3'd1;
    cfg_valid = 1'b1;
    rst       = 1'b1;
    #1;
    chk("mid_rst_led", 32'(LED), 32'd0);
    chk("mid_rst_state", 32'(link_state), 32'd0);
    chk("mid_rst_drop", 32'(link_drop_cnt), 32'd0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
    chk("mid_rst_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    cfg_valid = 1'b0;
    model_reset();
    run_check(10, "post_rst_led");
    cfg_write(5, 2, 0);
    cfg_write(6, 6, 0);
    run_check(1300, "post_rst_heart_slow");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
